// File: rtl/instr_reg_decode_pkg.sv
// Shared RV64I decode definitions: base opcodes, immediate format codes and the canonical NOP.
// No logic here; imported by the instruction register, its bus interface and the immediate generator.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_U  = 3'd4,
        FMT_UJ = 3'd5
    } imm_fmt_e;

    function automatic logic opcode_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
            OP_OPIMM, OP_OPIMM32, OP_OP, OP_OP32, OP_SYSTEM: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_reg_decode_if.sv
// Fetch handshake plus decoded-field bus between control unit (master) and instruction register (slave).
// Optional ILLEGAL_OPCODE_CHECK_EN adds the illegal_instr flag.
interface instr_reg_decode_if;
    import riscv_pkg::*;

    logic        fetch_req;
    logic [31:0] mem_data;
    logic        instr_ack;
    logic        busy;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [63:0] imm;
    imm_fmt_e    imm_fmt;
`ifdef ILLEGAL_OPCODE_CHECK_EN
    logic        illegal_instr;
`endif

    modport master (
        output fetch_req, mem_data, instr_ack,
        input  busy, instr_valid, instr, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_fmt
`ifdef ILLEGAL_OPCODE_CHECK_EN
        , input illegal_instr
`endif
    );

    modport slave (
        input  fetch_req, mem_data, instr_ack,
        output busy, instr_valid, instr, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_fmt
`ifdef ILLEGAL_OPCODE_CHECK_EN
        , output illegal_instr
`endif
    );

endinterface

// File: rtl/instr_reg_decode_imm_gen.sv
// Purely combinational RV64I immediate generator: 32-bit instruction in, 64-bit sign-extended immediate and format out.
// Zero latency, no handshake; unknown opcodes decode as R with a zero immediate.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [63:0] imm_o,
    output imm_fmt_e    imm_fmt_o
);

    always_comb begin
        imm_o     = '0;
        imm_fmt_o = FMT_R;
        case (instr_i[6:0])
            OP_LOAD, OP_OPIMM, OP_OPIMM32, OP_JALR, OP_SYSTEM: begin
                imm_o     = {{52{instr_i[31]}}, instr_i[31:20]};
                imm_fmt_o = FMT_I;
            end
            OP_STORE: begin
                imm_o     = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                imm_fmt_o = FMT_S;
            end
            OP_BRANCH: begin
                imm_o     = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
                imm_fmt_o = FMT_SB;
            end
            OP_LUI, OP_AUIPC: begin
                imm_o     = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
                imm_fmt_o = FMT_U;
            end
            OP_JAL: begin
                imm_o     = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
                imm_fmt_o = FMT_UJ;
            end
            default: begin
                imm_o     = '0;
                imm_fmt_o = FMT_R;
            end
        endcase
    end

endmodule

// File: rtl/instr_reg_decode.sv
// Instruction register: waits MEM_LATENCY edges after fetch_req, latches mem_data, holds it until instr_ack.
// Backpressure: fetch_req is ignored while busy or while an unacknowledged word is held. Optional ILLEGAL_OPCODE_CHECK_EN.
module instr_reg_decode
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    instr_reg_decode_if.slave   bus
);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("instr_reg_decode: MEM_LATENCY must be >= 1");
    end

    localparam int unsigned     CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ir_q;
    logic             busy_q;
    logic             valid_q;
    logic [63:0]      imm;
    imm_fmt_e         imm_fmt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ir_q    <= RESET_INSTR;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.fetch_req) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        ir_q    <= bus.mem_data;
                        state_q <= S_VALID;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    // ack together with a new request chains straight into the next read
                    if (bus.instr_ack) begin
                        valid_q <= 1'b0;
                        if (bus.fetch_req) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_LOAD;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ILLEGAL_OPCODE_CHECK_EN
    logic illegal_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_WAIT && cnt_q == '0) begin
            illegal_q <= !opcode_supported(bus.mem_data[6:0]) || (bus.mem_data[1:0] != 2'b11);
        end
    end

    assign bus.illegal_instr = illegal_q;
`endif

    imm_gen u_imm_gen (
        .instr_i   (ir_q),
        .imm_o     (imm),
        .imm_fmt_o (imm_fmt)
    );

    assign bus.busy        = busy_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = ir_q;
    assign bus.opcode      = ir_q[6:0];
    assign bus.rd          = ir_q[11:7];
    assign bus.funct3      = ir_q[14:12];
    assign bus.rs1         = ir_q[19:15];
    assign bus.rs2         = ir_q[24:20];
    assign bus.funct7      = ir_q[31:25];
    assign bus.imm         = imm;
    assign bus.imm_fmt     = imm_fmt;

endmodule

// File: tb/tb_instr_reg_decode.sv
// Bench for instr_reg_decode at MEM_LATENCY=1 and MEM_LATENCY=3; expected captures are queued by the
// stimulus and scored by per-DUT monitors on each rising instr_valid.
module tb_instr_reg_decode;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        imm_fmt_e    fmt;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    instr_reg_decode_if if1 ();
    instr_reg_decode_if if3 ();

    instr_reg_decode #(.MEM_LATENCY(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
    instr_reg_decode #(.MEM_LATENCY(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input int now,
                         input logic [31:0] instr, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] f7, input logic [63:0] imm, input logic [2:0] fmt,
                         input logic ill);
        chk({tag, "_cycle"},  64'(now),    64'(e.cyc));
        chk({tag, "_instr"},  64'(instr),  64'(e.instr));
        chk({tag, "_opcode"}, 64'(opc),    64'(e.instr[6:0]));
        chk({tag, "_rd"},     64'(rd),     64'(e.instr[11:7]));
        chk({tag, "_funct3"}, 64'(f3),     64'(e.instr[14:12]));
        chk({tag, "_rs1"},    64'(rs1),    64'(e.instr[19:15]));
        chk({tag, "_rs2"},    64'(rs2),    64'(e.instr[24:20]));
        chk({tag, "_funct7"}, 64'(f7),     64'(e.instr[31:25]));
        chk({tag, "_imm"},    imm,         e.imm);
        chk({tag, "_fmt"},    64'(fmt),    64'(e.fmt));
`ifdef ILLEGAL_OPCODE_CHECK_EN
        chk({tag, "_illegal"}, 64'(ill),   64'(e.ill));
`else
        if (ill !== 1'b0) chk({tag, "_illegal_absent"}, 64'(ill), 64'd0);
`endif
    endtask

    logic pv1 = 1'b0;
    logic pv3 = 1'b0;
    logic ill1, ill3;
`ifdef ILLEGAL_OPCODE_CHECK_EN
    assign ill1 = if1.illegal_instr;
    assign ill3 = if3.illegal_instr;
`else
    assign ill1 = 1'b0;
    assign ill3 = 1'b0;
`endif

    always @(negedge clk) begin
        if (if1.instr_valid === 1'b1 && !pv1) begin
            if (q1.size() == 0) chk("l1_unexpected_capture", 64'(if1.instr), 64'hx);
            else score("l1", q1.pop_front(), cyc, if1.instr, if1.opcode, if1.rd, if1.funct3,
                       if1.rs1, if1.rs2, if1.funct7, if1.imm, if1.imm_fmt, ill1);
        end
        pv1 = (if1.instr_valid === 1'b1);
    end

    always @(negedge clk) begin
        if (if3.instr_valid === 1'b1 && !pv3) begin
            if (q3.size() == 0) chk("l3_unexpected_capture", 64'(if3.instr), 64'hx);
            else score("l3", q3.pop_front(), cyc, if3.instr, if3.opcode, if3.rd, if3.funct3,
                       if3.rs1, if3.rs2, if3.funct7, if3.imm, if3.imm_fmt, ill3);
        end
        pv3 = (if3.instr_valid === 1'b1);
    end

    task automatic drive(input int sel, input logic f, input logic [31:0] d, input logic a);
        if (sel == 1) begin
            if1.fetch_req = f; if1.mem_data = d; if1.instr_ack = a;
        end else begin
            if3.fetch_req = f; if3.mem_data = d; if3.instr_ack = a;
        end
    endtask

    function automatic logic vld(input int sel);
        return (sel == 1) ? if1.instr_valid : if3.instr_valid;
    endfunction

    task automatic expect_capture(input int sel, input logic [31:0] w, input logic [63:0] imm,
                                  input imm_fmt_e fmt, input logic ill, input int at);
        exp_t e;
        e.instr = w; e.imm = imm; e.fmt = fmt; e.ill = ill; e.cyc = at;
        if (sel == 1) q1.push_back(e);
        else          q3.push_back(e);
    endtask

    task automatic wait_valid(input int sel, input string name);
        for (int i = 0; i < 20 && vld(sel) !== 1'b1; i++) @(negedge clk);
        if (vld(sel) !== 1'b1) chk({name, "_valid_timeout"}, 64'(vld(sel)), 64'd1);
    endtask

    // Full fetch / hold / ack cycle; fetch_req is sampled on the edge after this negedge.
    task automatic fetch(input int sel, input int lat, input logic [31:0] w, input logic [63:0] imm,
                         input imm_fmt_e fmt, input logic ill);
        @(negedge clk);
        drive(sel, 1'b1, w, 1'b0);
        expect_capture(sel, w, imm, fmt, ill, cyc + 1 + lat);
        @(negedge clk);
        drive(sel, 1'b0, w, 1'b0);
        wait_valid(sel, "fetch");
        repeat (2) @(negedge clk);
        drive(sel, 1'b0, w, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, w, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1, 1'b0, 32'h0, 1'b0);
        drive(3, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_l1_instr", 64'(if1.instr),       64'h13);
        chk("rst_l1_valid", 64'(if1.instr_valid), 64'd0);
        chk("rst_l1_busy",  64'(if1.busy),        64'd0);
        chk("rst_l1_imm",   if1.imm,              64'd0);
        chk("rst_l1_rd",    64'(if1.rd),          64'd0);
        chk("rst_l1_fmt",   64'(if1.imm_fmt),     64'(FMT_I));
        chk("rst_l3_instr", 64'(if3.instr),       64'h13);
        chk("rst_l3_valid", 64'(if3.instr_valid), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fetch(1, 1, 32'hFFF30293, 64'hFFFFFFFFFFFFFFFF, FMT_I,  1'b0);
        fetch(1, 1, 32'h0020B423, 64'h0000000000000008, FMT_S,  1'b0);
        fetch(1, 1, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, FMT_SB, 1'b0);
        fetch(1, 1, 32'h12345537, 64'h0000000012345000, FMT_U,  1'b0);
        fetch(1, 1, 32'h80000517, 64'hFFFFFFFF80000000, FMT_U,  1'b0);
        fetch(1, 1, 32'h008000EF, 64'h0000000000000008, FMT_UJ, 1'b0);
        fetch(1, 1, 32'h00B50533, 64'h0000000000000000, FMT_R,  1'b0);
        fetch(1, 1, 32'h0000007F, 64'h0000000000000000, FMT_R,  1'b1);

        // Latency 3: fetch, then try to disturb the held word
        @(negedge clk);
        drive(3, 1'b1, 32'h0020B423, 1'b0);
        expect_capture(3, 32'h0020B423, 64'd8, FMT_S, 1'b0, cyc + 4);
        @(negedge clk);
        drive(3, 1'b0, 32'h0020B423, 1'b0);
        chk("l3_busy_in_wait", 64'(if3.busy), 64'd1);
        wait_valid(3, "l3_first");
        @(negedge clk);
        drive(3, 1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        drive(3, 1'b0, 32'hDEADBEEF, 1'b0);
        repeat (4) @(negedge clk);
        chk("l3_hold_instr", 64'(if3.instr),       64'h0020B423);
        chk("l3_hold_valid", 64'(if3.instr_valid), 64'd1);
        chk("l3_hold_busy",  64'(if3.busy),        64'd0);

        // ack and new request in the same cycle
        drive(3, 1'b1, 32'hFFF30293, 1'b1);
        expect_capture(3, 32'hFFF30293, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0, cyc + 4);
        @(negedge clk);
        drive(3, 1'b0, 32'hFFF30293, 1'b0);
        chk("b2b_busy",  64'(if3.busy),        64'd1);
        chk("b2b_valid", 64'(if3.instr_valid), 64'd0);
        wait_valid(3, "b2b");
        @(negedge clk);
        drive(3, 1'b0, 32'hFFF30293, 1'b1);
        @(negedge clk);
        drive(3, 1'b0, 32'hFFF30293, 1'b0);

        // reset while waiting on memory: capture must be dropped
        @(negedge clk);
        drive(3, 1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        drive(3, 1'b0, 32'hDEADBEEF, 1'b0);
        chk("rstw_busy_before", 64'(if3.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_busy",  64'(if3.busy),        64'd0);
        chk("rstw_valid", 64'(if3.instr_valid), 64'd0);
        chk("rstw_instr", 64'(if3.instr),       64'h13);
        chk("rstw_imm",   if3.imm,              64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstw_after_valid", 64'(if3.instr_valid), 64'd0);
        chk("rstw_after_busy",  64'(if3.busy),        64'd0);
        chk("rstw_after_instr", 64'(if3.instr),       64'h13);

        repeat (2) @(negedge clk);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_reg_decode.md
Name: instr_reg_decode

Overview:
- Instruction register and field decoder for the multicycle RV64I datapath.
- Sits directly downstream of the 32-bit instruction memory read port and consumes its Dataout word.
- Sequences the memory read latency under a req/valid/ack handshake with the control unit, latches the word, and presents decoded fields plus a 64-bit sign-extended immediate.
- Its outputs feed the control unit, the register file and the ALU operand muxes.

Parameters:
- MEM_LATENCY, 1, cycles from fetch_req acceptance to mem_data being valid; must be >=1. A value of 0 is an elaboration error.
- RESET_INSTR, 32'h00000013, IR contents after reset (NOP, addi x0,x0,0).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control unit requests capture of the word currently being read.
- mem_data  in  32  instruction memory Dataout.
- instr_ack  in  1  control unit has consumed the current instruction.
- busy  out  1  high in WAIT.
- instr_valid  out  1  high in VALID.
- instr  out  32  registered instruction word (IR).
- opcode  out  7  IR[6:0].
- rd  out  5  IR[11:7].
- funct3  out  3  IR[14:12].
- rs1  out  5  IR[19:15].
- rs2  out  5  IR[24:20].
- funct7  out  7  IR[31:25].
- imm  out  64  sign-extended immediate.
- imm_fmt  out  3  format code: R/I/S/SB/U/UJ.

Behaviour:
- Reset (Reset=0, asynchronous, any state): state=IDLE, cnt=0, IR=RESET_INSTR, busy=0, instr_valid=0.
  - Any in-flight capture is discarded.
  - After release, the first action requires a new fetch_req.
- FSM states: IDLE, WAIT, VALID.
- IDLE:
  - fetch_req=1 at edge t0 -> WAIT, cnt loaded with MEM_LATENCY-1.
- WAIT:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> IR<=mem_data, next state VALID.
  - Net effect: capture occurs at edge t0+MEM_LATENCY, and instr_valid is high from that edge.
  - fetch_req and instr_ack are ignored in WAIT.
- VALID:
  - IR holds and instr_valid stays 1 until instr_ack.
  - instr_ack=1 and fetch_req=0 -> IDLE.
  - instr_ack=1 and fetch_req=1 in the same cycle -> WAIT directly (back-to-back fetch, no IDLE bubble), cnt=MEM_LATENCY-1.
  - fetch_req without instr_ack -> ignored; IR is never overwritten before ack.
- Field outputs, imm and imm_fmt are combinational from IR only, never from mem_data. They are therefore stable while instr_valid=1 and equal the RESET_INSTR decode after reset.
- Immediate generation (all bit 31 sign-extended to 64):
  - I, opcodes 0000011/0010011/0011011/1100111/1110011: IR[31:20].
  - S, opcode 0100011: {IR[31:25],IR[11:7]}.
  - SB, opcode 1100011: {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
  - U, opcodes 0110111/0010111: {IR[31:12],12'b0}, sign-extended from bit 31.
  - UJ, opcode 1101111: {IR[31],IR[19:12],IR[20],IR[30:21],1'b0}.
  - R (0110011/0111011) and any other opcode: imm=0, imm_fmt=R.
- Counter width: $clog2(MEM_LATENCY+1); the counter never wraps.

Optional Feature:
- Macro: ILLEGAL_OPCODE_CHECK_EN.
- Defined:
  - Adds output illegal_instr (1 bit), registered alongside IR.
  - Set at capture when opcode is not in the supported set above, or IR[1:0]!=2'b11.
  - Cleared on reset and on every new capture.
  - Reset value 0.
- Undefined:
  - The port is absent and there is no logic; the decode of unknown opcodes is unchanged (imm=0, fmt=R).

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OPIMM, OP_OPIMM32, OP_OP, OP_OP32, OP_SYSTEM);
  - enum imm_fmt_e {FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ};
  - the NOP constant.
- One combinational sub-module, imm_gen (32-bit instr in; 64-bit imm and imm_fmt out), so the immediate logic can be reused and unit-tested alone.

Test Plan:
- Reset: hold Reset=0 -> instr=0x00000013, instr_valid=0, busy=0, imm=0, rd=0.
- Fetch 0xFFF30293 (addi x5,x6,-1), MEM_LATENCY=1:
  - instr_valid rises exactly 1 edge after fetch_req.
  - opcode=0010011, rd=5, rs1=6, imm=0xFFFFFFFFFFFFFFFF, fmt=I.
- Fetch 0x0020B423 (sd x2,8(x1)) -> rs1=1, rs2=2, funct3=3, imm=8, fmt=S.
- Fetch 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFFFFFFFFFC, fmt=SB.
- Fetch 0x12345537 (lui x10) -> imm=0x0000000012345000.
- Fetch 0x008000EF (jal x1,+8) -> imm=8, fmt=UJ.
- Handshake and reset stress, MEM_LATENCY=3:
  - Fetch, then change mem_data to 0xDEADBEEF while VALID -> instr unchanged.
  - ack+fetch_req in the same cycle -> busy next cycle, valid 3 edges later.
  - Reset asserted in WAIT -> IDLE, IR=NOP, no capture.
